// File: rtl/regbank_mp_pkg.sv
// regbank_mp_pkg: shared constants for the multi-port register bank.
//   SRC_*      write-data source select encodings (MS input)
//   MAX_DEPTH  largest supported register count
//   NUM_RD     number of read ports instantiated by the top
package regbank_mp_pkg;
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_REG  = 2'b01;
  localparam logic [1:0] SRC_IMM  = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;
  localparam int MAX_DEPTH = 64;
  localparam int NUM_RD    = 2;
endpackage

// File: rtl/regbank_rdport.sv
// regbank_rdport: combinational read port of the register bank.
//   regs/busy   stored register contents and busy bits
//   ra          read address; addresses >= DEPTH read data 0, busy 0
//   wr_en/wa/wd accepted write of the current cycle (bypass source)
//   rsv_en/rsv_a accepted reserve of the current cycle (bypass busy)
//   rd/bsy      read data and busy flag
// Optional: REGBANK_BYPASS_EN forwards a same-cycle write to this port.
module regbank_rdport
  import regbank_mp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy,
  input  logic [ADDR_W-1:0]           ra,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wa,
  input  logic [WIDTH-1:0]            wd,
  input  logic                        rsv_en,
  input  logic [ADDR_W-1:0]           rsv_a,
  output logic [WIDTH-1:0]            rd,
  output logic                        bsy
);
  logic in_rng;
  assign in_rng = 32'(ra) < DEPTH;

`ifndef REGBANK_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_en, wa, wd, rsv_en, rsv_a};
`endif

  always_comb begin
    rd  = '0;
    bsy = 1'b0;
    if (in_rng) begin
      rd  = regs[ra];
      bsy = busy[ra];
`ifdef REGBANK_BYPASS_EN
      // wr_en is already range-qualified, so a hit implies an in-range wa.
      // The write clears busy unless a reserve lands on the same register.
      if (wr_en && (wa == ra)) begin
        rd  = wd;
        bsy = rsv_en && (rsv_a == ra);
      end
`endif
    end
  end
endmodule

// File: rtl/regbank_mp.sv
// regbank_mp: DEPTH x WIDTH register bank, one write port, two read ports,
// per-register busy scoreboard.
//   CLK, RSTN      clock, synchronous active-low reset
//   E              global enable for writes and reserves
//   WE, WA, MS     write request, address, source select (ALU/REG/IMM/zero)
//   ALU, REG, IMM  write data sources
//   RA0/RA1        read addresses -> RD0/RD1 data, BUSY0/BUSY1 flags
//   RSV, RSV_A     reserve request and address (sets busy)
//   RALL           flat view, register i at [i*WIDTH +: WIDTH]
// Optional: REGBANK_BYPASS_EN enables same-cycle write forwarding on reads.
module regbank_mp
  import regbank_mp_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   E,
  input  logic                   WE,
  input  logic [ADDR_W-1:0]      WA,
  input  logic [1:0]             MS,
  input  logic [WIDTH-1:0]       ALU,
  input  logic [WIDTH-1:0]       REG,
  input  logic [WIDTH-1:0]       IMM,
  input  logic [ADDR_W-1:0]      RA0,
  input  logic [ADDR_W-1:0]      RA1,
  output logic [WIDTH-1:0]       RD0,
  output logic [WIDTH-1:0]       RD1,
  input  logic                   RSV,
  input  logic [ADDR_W-1:0]      RSV_A,
  output logic                   BUSY0,
  output logic                   BUSY1,
  output logic [DEPTH*WIDTH-1:0] RALL
);
  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("regbank_mp: DEPTH out of range");
  end

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            busy;
  logic [WIDTH-1:0]            wd;
  logic                        wr_ok, rsv_ok;

  always_comb begin
    wd = '0;
    case (MS)
      SRC_ALU:  wd = ALU;
      SRC_REG:  wd = REG;
      SRC_IMM:  wd = IMM;
      default:  wd = '0;
    endcase
  end

  // Out-of-range targets (non power-of-two DEPTH) are dropped here.
  assign wr_ok  = E && WE  && (32'(WA)    < DEPTH);
  assign rsv_ok = E && RSV && (32'(RSV_A) < DEPTH);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[WA]  <= wd;
        busy[WA] <= 1'b0;
      end
      // Later assignment wins: a reserve to the written register keeps it busy.
      if (rsv_ok) busy[RSV_A] <= 1'b1;
    end
  end

  assign RALL = mem;

  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd;
  logic [NUM_RD-1:0]             bsy;

  assign ra = {RA1, RA0};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd (
      .regs  (mem),
      .busy  (busy),
      .ra    (ra[p]),
      .wr_en (wr_ok),
      .wa    (WA),
      .wd    (wd),
      .rsv_en(rsv_ok),
      .rsv_a (RSV_A),
      .rd    (rd[p]),
      .bsy   (bsy[p])
    );
  end

  assign RD0   = rd[0];
  assign RD1   = rd[1];
  assign BUSY0 = bsy[0];
  assign BUSY1 = bsy[1];
endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: drives a DEPTH=8 and a DEPTH=6 bank from shared stimulus,
// checks both against a bench model every negative edge, plus literal pins.
module tb_regbank_mp;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RSTN, E, WE, RSV;
  logic [2:0] WA, RA0, RA1, RSV_A;
  logic [1:0] MS;
  logic [7:0] ALU, REG, IMM;

  logic [7:0]  rd0_8, rd1_8, rd0_6, rd1_6;
  logic        b0_8, b1_8, b0_6, b1_6;
  logic [63:0] rall8;
  logic [47:0] rall6;

  regbank_mp u8 (
    .CLK(CLK), .RSTN(RSTN), .E(E), .WE(WE), .WA(WA), .MS(MS),
    .ALU(ALU), .REG(REG), .IMM(IMM), .RA0(RA0), .RA1(RA1),
    .RD0(rd0_8), .RD1(rd1_8), .RSV(RSV), .RSV_A(RSV_A),
    .BUSY0(b0_8), .BUSY1(b1_8), .RALL(rall8)
  );

  regbank_mp #(.WIDTH(8), .DEPTH(6)) u6 (
    .CLK(CLK), .RSTN(RSTN), .E(E), .WE(WE), .WA(WA), .MS(MS),
    .ALU(ALU), .REG(REG), .IMM(IMM), .RA0(RA0), .RA1(RA1),
    .RD0(rd0_6), .RD1(rd1_6), .RSV(RSV), .RSV_A(RSV_A),
    .BUSY0(b0_6), .BUSY1(b1_6), .RALL(rall6)
  );

  int checks = 0, failures = 0;
  bit chk_en = 0;

  // Model state: register contents and busy bits per bank.
  logic [7:0] m8 [8];
  bit         k8 [8];
  logic [7:0] m6 [8];
  bit         k6 [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] src_data();
    case (MS)
      2'd0: return ALU;
      2'd1: return REG;
      2'd2: return IMM;
      default: return 8'h00;
    endcase
  endfunction

  // Expected {busy, data} of a read at address a for a bank of given depth.
  function automatic logic [8:0] exp_rd(int depth, logic [2:0] a, logic [7:0] sv, bit sb);
    if (int'(a) >= depth) return 9'd0;
`ifdef REGBANK_BYPASS_EN
    if (E && WE && WA == a) return {(E && RSV && RSV_A == a), src_data()};
`endif
    return {sb, sv};
  endfunction

  // Model update: reset clears; per register, a reserve forces busy, a write
  // loads data and clears busy, targets past depth are ignored.
  always @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      bit wh, rh;
      wh = E && WE && WA == i;
      rh = E && RSV && RSV_A == i;
      if (!RSTN) begin
        m8[i] <= 8'h00; k8[i] <= 1'b0; m6[i] <= 8'h00; k6[i] <= 1'b0;
      end else begin
        if (wh) m8[i] <= src_data();
        k8[i] <= rh ? 1'b1 : (wh ? 1'b0 : k8[i]);
        if (i < 6) begin
          if (wh) m6[i] <= src_data();
          k6[i] <= rh ? 1'b1 : (wh ? 1'b0 : k6[i]);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [8:0]  e;
      logic [63:0] ra8;
      logic [47:0] ra6;
      e = exp_rd(8, RA0, m8[RA0], k8[RA0]);
      chk("u8_rd0", rd0_8, e[7:0]); chk("u8_busy0", b0_8, e[8]);
      e = exp_rd(8, RA1, m8[RA1], k8[RA1]);
      chk("u8_rd1", rd1_8, e[7:0]); chk("u8_busy1", b1_8, e[8]);
      e = exp_rd(6, RA0, m6[RA0], k6[RA0]);
      chk("u6_rd0", rd0_6, e[7:0]); chk("u6_busy0", b0_6, e[8]);
      e = exp_rd(6, RA1, m6[RA1], k6[RA1]);
      chk("u6_rd1", rd1_6, e[7:0]); chk("u6_busy1", b1_6, e[8]);
      for (int i = 0; i < 8; i++) ra8[i*8 +: 8] = m8[i];
      for (int i = 0; i < 6; i++) ra6[i*8 +: 8] = m6[i];
      chk("u8_rall", rall8, ra8);
      chk("u6_rall", {16'h0, rall6}, {16'h0, ra6});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    E = 1'b0; WE = 1'b0; RSV = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] ms, input logic [7:0] d);
    E = 1'b1; WE = 1'b1; RSV = 1'b0; WA = a; MS = ms;
    ALU = d; REG = ~d; IMM = d;
    if (ms == 2'd1) REG = d;
    step();
  endtask

  initial begin
    RSTN = 1'b0; E = 1'b1; WE = 1'b1; WA = 3'd0; MS = 2'b10;
    ALU = 8'h00; REG = 8'h00; IMM = 8'd10;
    RA0 = 3'd0; RA1 = 3'd1; RSV = 1'b1; RSV_A = 3'd1;

    // Reset overrides the write and reserve in the same cycle.
    step();
    chk_en = 1;
    idle(); RSTN = 1'b1; #1;
    chk("rst_rall8", rall8, 64'h0);
    chk("rst_rall6", {16'h0, rall6}, 64'h0);
    chk("rst_busy0", b0_8, 1'b0);
    chk("rst_busy1", b1_8, 1'b0);

    // Source select.
    wr(3'd0, 2'b10, 8'd10);
    wr(3'd3, 2'b00, 8'h5A);
    wr(3'd7, 2'b01, 8'hFF);
    wr(3'd7, 2'b11, 8'hC3);
    idle(); RA0 = 3'd0; RA1 = 3'd3; #1;
    chk("src_imm_r0", rd0_8, 8'd10);
    chk("src_alu_r3", rd1_8, 8'h5A);
    chk("mdl_r3", m8[3], 8'h5A);
    RA0 = 3'd7; #1;
    chk("src_zero_r7", rd0_8, 8'h00);

    // Enable gating.
    wr(3'd2, 2'b10, 8'h21);
    E = 1'b0; WE = 1'b1; WA = 3'd2; MS = 2'b10; IMM = 8'h33; RSV = 1'b1; RSV_A = 3'd2;
    step();
    idle(); RA0 = 3'd2; #1;
    chk("gate_r2", rd0_8, 8'h21);
    chk("gate_busy2", b0_8, 1'b0);

    // Scoreboard.
    E = 1'b1; RSV = 1'b1; RSV_A = 3'd4; step();
    idle(); RA0 = 3'd4; #1;
    chk("rsv4_busy", b0_8, 1'b1);
    chk("mdl_k4", k8[4], 1'b1);
    wr(3'd4, 2'b10, 8'h11);
    idle(); #1;
    chk("wr4_busy", b0_8, 1'b0);
    chk("wr4_data", rd0_8, 8'h11);
    E = 1'b1; WE = 1'b1; WA = 3'd4; MS = 2'b10; IMM = 8'h44; RSV = 1'b1; RSV_A = 3'd4;
    step();
    idle(); #1;
    chk("rsvwr4_busy", b0_8, 1'b1);
    chk("rsvwr4_data", rd0_8, 8'h44);
    E = 1'b1; WE = 1'b1; WA = 3'd4; MS = 2'b10; IMM = 8'h55; RSV = 1'b1; RSV_A = 3'd1;
    step();
    idle(); RA0 = 3'd1; RA1 = 3'd4; #1;
    chk("diff_busy1", b0_8, 1'b1);
    chk("diff_busy4", b1_8, 1'b0);
    chk("diff_data4", rd1_8, 8'h55);

    // Same-cycle write to a read address.
    RA1 = 3'd5; E = 1'b1; WE = 1'b1; WA = 3'd5; MS = 2'b10; IMM = 8'h77; #1;
`ifdef REGBANK_BYPASS_EN
    chk("byp_rd1", rd1_8, 8'h77);
`else
    chk("byp_rd1", rd1_8, 8'h00);
`endif
    step();
    idle(); #1;
    chk("post_byp_rd1", rd1_8, 8'h77);

    // Out-of-range address on the DEPTH=6 bank.
    E = 1'b1; WE = 1'b1; WA = 3'd6; MS = 2'b10; IMM = 8'h99; RSV = 1'b1; RSV_A = 3'd6;
    RA0 = 3'd6; #1;
    chk("oor_rd0_pre", rd0_6, 8'h00);
    step();
    idle(); #1;
    chk("oor_rd0", rd0_6, 8'h00);
    chk("oor_busy0", b0_6, 1'b0);
    chk("oor_rall6", {16'h0, rall6}, 64'h0000_7755_5A21_000A);
    chk("u8_rall_r6", rall8, 64'h0099_7755_5A21_000A);
    chk("u8_busy6", b0_8, 1'b1);

    // Reset discards an outstanding reserve.
    RA0 = 3'd1; #1;
    chk("pre_rst_busy1", b0_8, 1'b1);
    RSTN = 1'b0; step();
    RSTN = 1'b1; #1;
    chk("rst2_busy1", b0_8, 1'b0);
    chk("rst2_rall8", rall8, 64'h0);

    // Fill every address through each source; model check covers reads.
    for (int i = 0; i < 8; i++) begin
      RA0 = 3'(i); RA1 = 3'(7 - i);
      wr(3'(i), 2'(i % 4), 8'(i * 17 + 3));
    end
    for (int i = 0; i < 8; i++) begin
      idle(); RA0 = 3'(i); RA1 = 3'((i + 3) % 8);
      E = 1'b1; RSV = (i % 2) == 0; RSV_A = 3'(i);
      step();
    end
    idle(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regbank_mp.md
# regbank_mp

Parametrised multi-port register bank: the successor to the fixed 8×8 register bank in the C0 datapath. It holds DEPTH registers of WIDTH bits and loads the selected register from one of ALU, REG, IMM or zero. It adds two independent read ports and a per-register busy scoreboard for the control unit's hazard checks. It sits between the control decoder and the ALU and replaces the single-enable, clock-gated bank with a properly clocked, resettable one.

## Interface
Parameters:
- WIDTH, 8, register width in bits
- DEPTH, 8, number of registers, 2..64; the derived local ADDR_W = $clog2(DEPTH)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RSTN  in  1  reset, synchronous, active-low
- E  in  1  global enable; gates both writes and reservations
- WE  in  1  write request
- WA  in  ADDR_W  write address
- MS  in  2  source select: 00 = ALU, 01 = REG, 10 = IMM, 11 = zero
- ALU, REG, IMM  in  WIDTH  write-data sources
- RA0, RA1  in  ADDR_W  read addresses
- RD0, RD1  out  WIDTH  read data
- RSV  in  1  reserve request: marks a register as having a pending producer
- RSV_A  in  ADDR_W  reserve address
- BUSY0, BUSY1  out  1  busy flag of the register at RA0 and RA1
- RALL  out  DEPTH*WIDTH  flat debug view; register i occupies bits [i*WIDTH +: WIDTH]

## Operation
- Write data WD is the MS-selected source. MS = 11 writes all-zero.
- Write: at a rising CLK with RSTN = 1, E = 1 and WE = 1, the register at WA loads WD. All other registers hold.
- Reads are combinational: RDn = reg[RAn]. Both ports may read the same address.
- Scoreboard: one busy bit per register.
  - RSV & E sets busy[RSV_A].
  - An accepted write clears busy[WA].
  - A write to a non-busy register is legal and leaves the bit at 0.
- Simultaneous reserve and write to the same address: the reserve wins, so the bit ends at 1. The data write still occurs.
- Simultaneous reserve and write to different addresses: both take effect.
- E = 0 blocks writes and reservations. Reads and BUSY outputs stay live.
- Out-of-range addresses (address ≥ DEPTH, possible only when DEPTH is not a power of two):
  - writes and reserves are ignored;
  - reads return 0 with BUSY = 0.
- Register 0 is an ordinary writable register; it is not hardwired to zero.

## Timing
- Reset: when RSTN = 0 at a rising edge, all registers clear to 0 and all busy bits clear to 0. RD0, RD1, BUSY0, BUSY1 and RALL are then 0.
- Reset priority: reset overrides any write or reserve in the same cycle.
- A reset asserted while a reserve is outstanding discards it.
- Write latency: 1 cycle. New data is visible on RDn and RALL after the rising edge that accepts the write.
- Busy latency: 1 cycle. BUSYn changes after the rising edge that sets or clears the bit.
- There is no handshake or back-pressure. Every qualified request is accepted in its cycle.

## Configuration
- REGBANK_BYPASS_EN defined:
  - When an accepted write targets RAn in the current cycle, RDn returns WD combinationally, not the stored value.
  - BUSYn reads 0 in that cycle, unless RSV targets the same address in the same cycle.
- REGBANK_BYPASS_EN undefined: RDn and BUSYn always reflect stored state; same-cycle writes are visible only after the edge.

## Structure
- A shared package holds:
  - the source-select constants SRC_ALU = 2'b00, SRC_REG = 2'b01, SRC_IMM = 2'b10, SRC_ZERO = 2'b11;
  - the max-depth constant (64).
- One sub-module, regbank_rdport: the combinational read mux (address → data plus busy flag, out-of-range → 0, optional bypass compare). It is instantiated twice.
- Storage, the source mux and the scoreboard live in the top module.

## Test plan
All scenarios use the defaults WIDTH = 8, DEPTH = 8 unless stated.
- Reset: hold RSTN = 0 with WE = 1, E = 1, MS = 10, IMM = 10 → after the edge, RALL = 0, BUSY0 = BUSY1 = 0.
- Source select: write WA = 0 from IMM = 10, WA = 3 from ALU = 0x5A, WA = 7 with MS = 11 over a prior value 0xFF → RA0 = 0 reads 10; RA1 = 3 reads 0x5A; register 7 reads 0.
- Enable gating: E = 0, WE = 1, WA = 2, IMM = 0x33, RSV = 1, RSV_A = 2 → register 2 and busy[2] are unchanged next cycle.
- Scoreboard:
  - Reserve address 4 → BUSY0 = 1 at RA0 = 4 the next cycle.
  - Write address 4 = 0x11 → BUSY0 = 0 and RD0 = 0x11 next cycle.
  - Reserve and write address 4 in the same cycle → BUSY0 = 1 and RD0 holds the new data.
- Bypass: write WA = 5 = 0x77 with RA1 = 5 in the same cycle → RD1 = 0x77 in that cycle with the macro defined; RD1 shows the old value with it undefined.
- Non-power-of-two: DEPTH = 6, write WA = 6 = 0x99, RA0 = 6 → RD0 = 0, BUSY0 = 0, RALL unchanged.
